seq_accumulator: RTL

SEQ_ACCUMULATOR -- requirements
Module: seq_accumulator

---
 rtl/seq_accumulator_pkg.sv | 13 +
 rtl/seq_accumulator_if.sv | 29 ++
 rtl/seq_accumulator_pa.sv | 22 ++
 rtl/seq_accumulator.sv | 95 +++++++++
 4 files changed

// File: rtl/seq_accumulator_pkg.sv
// Shared definitions for the packet accumulator: FSM encoding and default widths.
package seq_accumulator_pkg;

   localparam int SIZE_DEF  = 32;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no beats of the current packet seen yet
      ST_ACC  = 2'd1,   // packet in progress
      ST_HOLD = 2'd2    // result presented, waiting for downstream
   } state_e;

endpackage

// File: rtl/seq_accumulator_if.sv
// Beat-in / result-out handshake bundle for seq_accumulator.
interface seq_accumulator_if
   import seq_accumulator_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [SIZE-1:0]  in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [SIZE-1:0]  out_sum;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;

   // Producer of beats / consumer of results.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_count
   );

   // The accumulator side.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_count
   );
endinterface

// File: rtl/seq_accumulator_pa.sv
// PA: SIZE-bit parallel ripple-carry adder built from a chain of full adders.
module seq_accumulator_pa #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             ci_i,
   output logic [WIDTH-1:0] s_o,
   output logic             co_o
);
   logic [WIDTH:0] c;

   assign c[0] = ci_i;

   // One full adder per bit; carry ripples from bit 0 upward.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign co_o = c[WIDTH];
endmodule

// File: rtl/seq_accumulator.sv
// Packet accumulator: sums the beats of a packet, tracks carry-out and beat
// count, then holds the result until downstream takes it.
module seq_accumulator
   import seq_accumulator_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   seq_accumulator_if.slave   bus
);
   state_e           state_q, state_d;
   logic [SIZE-1:0]  acc_q,   acc_d;
   logic             ovf_q,   ovf_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [SIZE-1:0]  add_sum;
   logic             add_co;
   logic             accept;

   // Single adder: running sum plus the incoming operand.
   seq_accumulator_pa #(.WIDTH(SIZE)) u_pa (
      .a_i  (acc_q),
      .b_i  (bus.in_data),
      .ci_i (1'b0),
      .s_o  (add_sum),
      .co_o (add_co)
   );

   // Ready depends on state only, so no combinational path from out_ready.
   assign bus.in_ready  = (state_q != ST_HOLD);
   assign accept        = bus.in_valid && bus.in_ready;

   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_sum   = acc_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_count = cnt_q;

   // Next-state: load on first beat, accumulate afterwards, clear on result handshake.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               acc_d   = bus.in_data;
               ovf_d   = 1'b0;
               cnt_d   = CNT_W'(1);
               state_d = bus.in_last ? ST_HOLD : ST_ACC;
            end
         end
         ST_ACC: begin
            if (accept) begin
               acc_d   = add_sum;
               ovf_d   = ovf_q | add_co;
               // Count saturates; sum and overflow keep updating regardless.
               cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
               state_d = bus.in_last ? ST_HOLD : ST_ACC;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset discards any packet or held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
